ad7265_emu: RTL and testbench

- Synthesizable, parametrised emulator of a dual simultaneous-sampling SAR ADC serial port (AD7265 class).
- Runs on the board system clock and oversamples the controller's sclk/ncs.
- Serves captured channel words on two serial outputs with explicit output enables.
- Used in FPGA loopback and hardware-in-loop tests of the ADC readout path, where a delay-only behavioural model cannot synthesize.

---
 rtl/ad7265_emu_if.sv | 25 ++
 rtl/ad7265_emu.sv | 195 +++++++++++++++++++
 tb/tb_ad7265_emu.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad7265_emu_if.sv
// Serial port bundle between an ADC readout controller (master) and the AD7265 emulator (slave).
// The address width follows the channel count.
interface ad7265_emu_if #(
  parameter int N_CH = 8
);
  localparam int ADDR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              adc_sclk;
  logic              ncs;
  logic [ADDR_W-1:0] adc_addr;
  logic              twos_comp;
  logic              douta;
  logic              doutb;
  logic              dout_oe;

  modport master (
    output adc_sclk, ncs, adc_addr, twos_comp,
    input  douta, doutb, dout_oe
  );

  modport slave (
    input  adc_sclk, ncs, adc_addr, twos_comp,
    output douta, doutb, dout_oe
  );
endinterface

// File: rtl/ad7265_emu.sv
// System-clock emulator of a dual simultaneous-sampling SAR ADC serial port (AD7265 class).
// Define AD7265_EMU_DITHER_EN to add +/-1 LSB LFSR dither to the latched words.
module ad7265_emu #(
  parameter int DATA_W    = 12,
  parameter int N_CH      = 8,
  parameter int LEAD_Z    = 2,
  parameter int TRAIL_Z   = 2,
  parameter int DUAL_WORD = 1,
  parameter int DOUT_DLY  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] din_a,
  input  logic [N_CH*DATA_W-1:0] din_b,
  ad7265_emu_if.slave            bus,
  output logic                   frame_done,
  output logic                   frame_abort,
  output logic                   busy
);
  localparam int ADDR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int FW     = DATA_W + LEAD_Z + TRAIL_Z;
  localparam int F      = (DUAL_WORD != 0) ? 2 * FW : FW;
  localparam int CW     = $clog2(F);
  localparam logic [CW-1:0] CNT_TOP = CW'(F - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef struct packed {
    logic oe;
    logic a;
    logic b;
  } pins_t;

  logic sclk_meta, sclk_sync, sclk_prev;
  logic ncs_meta, ncs_sync, ncs_prev;

  // NOTE: non-blocking (<=) in every clocked block so each flop samples pre-edge values.
  // NOTE: the synchronizers stay out of reset so they keep tracking the pins through it and
  // no phantom edge appears on release.
  always_ff @(posedge clk) begin
    sclk_meta <= bus.adc_sclk;
    sclk_sync <= sclk_meta;
    sclk_prev <= sclk_sync;
    ncs_meta  <= bus.ncs;
    ncs_sync  <= ncs_meta;
    ncs_prev  <= ncs_sync;
  end

  logic sclk_fall, ncs_fall, ncs_rise;
  assign sclk_fall = sclk_prev & ~sclk_sync;
  assign ncs_fall  = ncs_prev & ~ncs_sync;
  assign ncs_rise  = ~ncs_prev & ncs_sync;

  // Channel select; addresses with no matching channel fall through to zero words.
  logic [DATA_W-1:0] word_a, word_b, dith_a, dith_b;
  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.adc_addr == k[ADDR_W-1:0]) begin
        word_a = din_a[k*DATA_W +: DATA_W];
        word_b = din_b[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef AD7265_EMU_DITHER_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (rst)           lfsr_q <= 16'hACE1;
    else if (ncs_fall) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  function automatic logic [DATA_W-1:0] dither(input logic [DATA_W-1:0] w, input logic [1:0] d);
    logic [DATA_W-1:0] r;
    r = w;
    if (d == 2'b01 && w != '1)      r = w + DATA_W'(1);
    else if (d == 2'b10 && w != '0) r = w - DATA_W'(1);
    return r;
  endfunction

  assign dith_a = dither(word_a, lfsr_q[1:0]);
  assign dith_b = dither(word_b, lfsr_q[1:0]);
`else
  assign dith_a = word_a;
  assign dith_b = word_b;
`endif

  function automatic logic [FW-1:0] frame_word(input logic [DATA_W-1:0] w, input logic tc);
    logic [DATA_W-1:0] c;
    c = w;
    if (tc) c[DATA_W-1] = ~c[DATA_W-1];
    return FW'(c) << TRAIL_Z;
  endfunction

  logic [FW-1:0] fw_a, fw_b;
  logic [F-1:0]  frame_a, frame_b;
  assign fw_a    = frame_word(dith_a, bus.twos_comp);
  assign fw_b    = frame_word(dith_b, bus.twos_comp);
  assign frame_a = (DUAL_WORD != 0) ? F'({fw_a, fw_b}) : F'(fw_a);
  assign frame_b = (DUAL_WORD != 0) ? F'({fw_b, fw_a}) : F'(fw_b);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [F-1:0]  sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic          done_d, abort_d;
  pins_t         raw_d, raw_q, pins_out;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: if (ncs_fall) begin
        state_d = SHIFT;
        cnt_d   = CNT_TOP;
        sh_a_d  = frame_a;
        sh_b_d  = frame_b;
      end
      SHIFT: begin
        // The counter sits on the bit being presented; the fall after bit 0 closes the frame.
        if (ncs_rise) begin
          state_d = IDLE;
          cnt_d   = CNT_TOP;
          abort_d = 1'b1;
        end else if (sclk_fall) begin
          if (cnt_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE: if (ncs_rise) begin
        state_d = IDLE;
        cnt_d   = CNT_TOP;
      end
      default: state_d = IDLE;
    endcase

    raw_d = '0;
    if (state_d == SHIFT) begin
      raw_d.oe = 1'b1;
      raw_d.a  = sh_a_d[cnt_d];
      raw_d.b  = sh_b_d[cnt_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_TOP;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      raw_q       <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      raw_q       <= raw_d;
      frame_done  <= done_d;
      frame_abort <= abort_d;
    end
  end

  generate
    if (DOUT_DLY == 0) begin : g_no_dly
      assign pins_out = raw_q;
    end else begin : g_dly
      pins_t line_q [DOUT_DLY];
      // NOTE: the delay line is an array but is still cleared on reset, flushing in-flight bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DOUT_DLY; i++) line_q[i] <= '0;
        end else begin
          line_q[0] <= raw_q;
          for (int i = 1; i < DOUT_DLY; i++) line_q[i] <= line_q[i-1];
        end
      end
      assign pins_out = line_q[DOUT_DLY-1];
    end
  endgenerate

  assign bus.douta   = pins_out.a;
  assign bus.doutb   = pins_out.b;
  assign bus.dout_oe = pins_out.oe;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_ad7265_emu.sv
// Bench for ad7265_emu: three instances (DOUT_DLY 4/0/7, N_CH 8/6/8) share one controller.
// Build with AD7265_EMU_DITHER_EN defined to run the dither sequence instead of the exact-frame table.
module tb_ad7265_emu;
  localparam int DATA_W = 12;
  localparam int HALF   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, sclk, ncs, twos_comp;
  logic [2:0]           adc_addr;
  logic [8*DATA_W-1:0]  din_a, din_b;
  logic                 fd0, fd1, fd2, fa0, fa1, fa2, bz0, bz1, bz2;
  int                   n_checks = 0;
  int                   n_err    = 0;

  ad7265_emu_if #(.N_CH(8)) if0 ();
  ad7265_emu_if #(.N_CH(6)) if1 ();
  ad7265_emu_if #(.N_CH(8)) if2 ();

  assign if0.adc_sclk = sclk;  assign if0.ncs = ncs;  assign if0.adc_addr = adc_addr;  assign if0.twos_comp = twos_comp;
  assign if1.adc_sclk = sclk;  assign if1.ncs = ncs;  assign if1.adc_addr = adc_addr;  assign if1.twos_comp = twos_comp;
  assign if2.adc_sclk = sclk;  assign if2.ncs = ncs;  assign if2.adc_addr = adc_addr;  assign if2.twos_comp = twos_comp;

  ad7265_emu #(.DOUT_DLY(4)) dut0 (
    .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b), .bus(if0),
    .frame_done(fd0), .frame_abort(fa0), .busy(bz0));
  ad7265_emu #(.N_CH(6), .DOUT_DLY(0)) dut1 (
    .clk(clk), .rst(rst), .din_a(din_a[6*DATA_W-1:0]), .din_b(din_b[6*DATA_W-1:0]), .bus(if1),
    .frame_done(fd1), .frame_abort(fa1), .busy(bz1));
  ad7265_emu #(.DOUT_DLY(7)) dut2 (
    .clk(clk), .rst(rst), .din_a(din_a), .din_b(din_b), .bus(if2),
    .frame_done(fd2), .frame_abort(fa2), .busy(bz2));

  int done_n [3];
  int abort_n [3];
  always @(posedge clk) begin
    if (fd0) done_n[0] <= done_n[0] + 1;
    if (fd1) done_n[1] <= done_n[1] + 1;
    if (fd2) done_n[2] <= done_n[2] + 1;
    if (fa0) abort_n[0] <= abort_n[0] + 1;
    if (fa1) abort_n[1] <= abort_n[1] + 1;
    if (fa2) abort_n[2] <= abort_n[2] + 1;
  end

  localparam int DLY [3] = '{4, 0, 7};

  // {oe, douta, doutb, busy, frame_done, frame_abort}
  function automatic logic [5:0] pins(input int d);
    case (d)
      0:       pins = {if0.dout_oe, if0.douta, if0.doutb, bz0, fd0, fa0};
      1:       pins = {if1.dout_oe, if1.douta, if1.doutb, bz1, fd1, fa1};
      default: pins = {if2.dout_oe, if2.douta, if2.doutb, bz2, fd2, fa2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] cap_a [3];
  logic [31:0] cap_b [3];
  logic        oe_ok [3];

  task automatic sample(input int bitn);
    for (int d = 0; d < 3; d++) begin
      logic [5:0] p;
      p = pins(d);
      cap_a[d][bitn] = p[4];
      cap_b[d][bitn] = p[3];
      oe_ok[d] = oe_ok[d] & p[5];
    end
  endtask

  // Drops ncs, then gives n_falls sclk cycles; bits are sampled just before each following fall.
  task automatic run_frame(input logic [2:0] addr, input logic tc, input int n_falls, input bit mid_change);
    for (int d = 0; d < 3; d++) begin
      cap_a[d] = '0;
      cap_b[d] = '0;
      oe_ok[d] = 1'b1;
    end
    @(negedge clk);
    adc_addr  = addr;
    twos_comp = tc;
    ncs       = 1'b0;
    wait_clk(HALF + 4);
    sample(31);
    for (int f = 1; f <= n_falls; f++) begin
      sclk = 1'b0;
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      if (mid_change && f == 10) begin
        adc_addr = 3'd0;
        din_a[3*DATA_W +: DATA_W] = 12'h000;
        din_b[3*DATA_W +: DATA_W] = 12'hFFF;
      end
      if (f <= 31) sample(31 - f);
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    ncs = 1'b1;
    wait_clk(12);
  endtask

  task automatic load_din();
    for (int k = 0; k < 8; k++) begin
      din_a[k*DATA_W +: DATA_W] = DATA_W'(k * 'h111);
      din_b[k*DATA_W +: DATA_W] = DATA_W'((k * 'h111) ^ 'hF0F);
    end
    din_a[0*DATA_W +: DATA_W] = 12'h000;  din_b[0*DATA_W +: DATA_W] = 12'hFFF;
    din_a[3*DATA_W +: DATA_W] = 12'hABC;  din_b[3*DATA_W +: DATA_W] = 12'h123;
    din_a[6*DATA_W +: DATA_W] = 12'hFFF;  din_b[6*DATA_W +: DATA_W] = 12'h000;
    din_a[7*DATA_W +: DATA_W] = 12'h555;  din_b[7*DATA_W +: DATA_W] = 12'hAAA;
  endtask

  task automatic pulse_reset_check(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) check($sformatf("%s_rst_pins_d%0d", tag, d), 32'(pins(d)), 32'h0);
    wait_clk(10);
    for (int d = 0; d < 3; d++) check($sformatf("%s_post_rst_idle_d%0d", tag, d), 32'(pins(d)), 32'h0);
    end_frame();
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        tc;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  initial begin
    rst = 1'b1; sclk = 1'b1; ncs = 1'b1; twos_comp = 1'b0; adc_addr = '0;
    load_din();
    vecs[0] = '{3'd3, 1'b0, 32'h2AF0048C, 32'h048C2AF0};
    vecs[1] = '{3'd3, 1'b1, 32'h0AF0248C, 32'h248C0AF0};
    vecs[2] = '{3'd0, 1'b0, 32'h00003FFC, 32'h3FFC0000};
    vecs[3] = '{3'd0, 1'b1, 32'h20001FFC, 32'h1FFC2000};
    vecs[4] = '{3'd7, 1'b0, 32'h15542AA8, 32'h2AA81554};
    vecs[5] = '{3'd6, 1'b0, 32'h3FFC0000, 32'h00003FFC};

    wait_clk(5);
    for (int d = 0; d < 3; d++) check($sformatf("reset_pins_d%0d", d), 32'(pins(d)), 32'h0);
    rst = 1'b0;
    wait_clk(4);

`ifdef AD7265_EMU_DITHER_EN
    begin
      logic [15:0] lf;
      int          n_up, n_dn;
      din_a[3*DATA_W +: DATA_W] = 12'hFFF;
      din_b[3*DATA_W +: DATA_W] = 12'h000;
      lf = 16'hACE1; n_up = 0; n_dn = 0;
      for (int fr = 0; fr < 110; fr++) begin
        logic [11:0] wa, wb, ea, eb;
        if (fr == 100) begin
          run_frame(3'd3, 1'b0, 5, 1'b0);
          pulse_reset_check("dither");
          lf = 16'hACE1;
        end
        ea = (lf[1:0] == 2'b10) ? 12'hFFE : 12'hFFF;
        eb = (lf[1:0] == 2'b01) ? 12'h001 : 12'h000;
        if (lf[1:0] == 2'b01) n_up++;
        if (lf[1:0] == 2'b10) n_dn++;
        run_frame(3'd3, 1'b0, 32, 1'b0);
        end_frame();
        for (int d = 0; d < 3; d += 2) begin
          wa = cap_a[d][29:18];
          wb = cap_a[d][13:2];
          check($sformatf("dither_f%0d_d%0d", fr, d), {8'h0, wa, wb}, {8'h0, ea, eb});
        end
        lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
      end
      check("dither_saw_both_offsets", 32'((n_up > 0) && (n_dn > 0)), 32'h1);
    end
`else
    for (int v = 0; v < 6; v++) begin
      int d0 [3];
      for (int d = 0; d < 3; d++) d0[d] = done_n[d];
      run_frame(vecs[v].addr, vecs[v].tc, 32, 1'b0);
      wait_clk(2 * HALF);
      for (int d = 0; d < 3; d++) begin
        logic [31:0] ea, eb;
        logic [5:0]  p;
        ea = (d == 1 && vecs[v].addr >= 3'd6) ? 32'h0 : vecs[v].exp_a;
        eb = (d == 1 && vecs[v].addr >= 3'd6) ? 32'h0 : vecs[v].exp_b;
        p  = pins(d);
        check($sformatf("v%0d_d%0d_douta", v, d), cap_a[d], ea);
        check($sformatf("v%0d_d%0d_doutb", v, d), cap_b[d], eb);
        check($sformatf("v%0d_d%0d_oe_in_frame", v, d), 32'(oe_ok[d]), 32'h1);
        check($sformatf("v%0d_d%0d_done_count", v, d), 32'(done_n[d] - d0[d]), 32'h1);
        check($sformatf("v%0d_d%0d_done_pins", v, d), 32'(p), 32'h04);
      end
      end_frame();
      for (int d = 0; d < 3; d++) check($sformatf("v%0d_d%0d_idle", v, d), 32'(pins(d)), 32'h0);
    end

    // Address and data rewritten after the tenth fall must not reach this frame.
    run_frame(3'd3, 1'b0, 32, 1'b1);
    check("midchange_douta", cap_a[0], 32'h2AF0048C);
    check("midchange_doutb", cap_b[0], 32'h048C2AF0);
    end_frame();
    load_din();

    // Abort after ten falls; dut0 must drop oe exactly DOUT_DLY+3 clks after ncs rises.
    begin
      int a0 [3];
      int n0 [3];
      logic [5:0] p;
      for (int d = 0; d < 3; d++) begin a0[d] = abort_n[d]; n0[d] = done_n[d]; end
      run_frame(3'd3, 1'b0, 10, 1'b0);
      ncs = 1'b1;
      wait_clk(6);
      p = pins(0);
      check("abort_d0_oe_still_high", 32'(p[5]), 32'h1);
      wait_clk(1);
      p = pins(0);
      check("abort_d0_oe_low", 32'(p[5]), 32'h0);
      check("abort_d0_busy", 32'(p[2]), 32'h0);
      wait_clk(3);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("abort_d%0d_pins", d), 32'(pins(d)), 32'h0);
        check($sformatf("abort_d%0d_count", d), 32'(abort_n[d] - a0[d]), 32'h1);
        check($sformatf("abort_d%0d_no_done", d), 32'(done_n[d] - n0[d]), 32'h0);
      end
      wait_clk(4);
      run_frame(3'd3, 1'b0, 32, 1'b0);
      check("after_abort_douta", cap_a[0], 32'h2AF0048C);
      check("after_abort_doutb", cap_b[2], 32'h048C2AF0);
      end_frame();
    end

    // The second fall presents bit 29 (the first 1 of 0x2AF0048C); time its arrival per instance.
    begin
      int seen [3];
      seen = '{-1, -1, -1};
      @(negedge clk);
      adc_addr = 3'd3; twos_comp = 1'b0; ncs = 1'b0;
      wait_clk(16);
      sclk = 1'b0; wait_clk(HALF); sclk = 1'b1; wait_clk(HALF);
      sclk = 1'b0;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
          logic [5:0] p;
          p = pins(d);
          if (seen[d] < 0 && p[4]) seen[d] = k;
        end
      end
      for (int d = 0; d < 3; d++) check($sformatf("latency_d%0d", d), 32'(seen[d]), 32'(3 + DLY[d]));
      sclk = 1'b1;
      wait_clk(HALF);
      end_frame();
    end

    run_frame(3'd3, 1'b0, 5, 1'b0);
    pulse_reset_check("midframe");
    run_frame(3'd3, 1'b1, 32, 1'b0);
    check("after_reset_douta", cap_a[0], 32'h0AF0248C);
    check("after_reset_doutb", cap_b[1], 32'h248C0AF0);
    end_frame();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
